// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory request/response handshake, byte-lane store
// formatting, load extraction/extension and pipeline stall generation.
module mem_access_stage #(
   parameter int unsigned TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_MEM,
   input  logic [31:0] ALU_out_MEM,
   input  logic [31:0] rs2_MEM,
   input  logic [2:0]  funct3_MEM,
   input  logic        mem_read_MEM,
   input  logic        mem_write_MEM,
   input  logic        hold_in,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_resp,
   output logic [31:0] dmem_address,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [3:0]  dmem_mbe,
   output logic [31:0] dmem_wdata,
   output logic [31:0] load_data,
   output logic        stall_mem,
   output logic        misaligned,
   output logic        timeout_err
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [3:0]        mbe_q, mbe_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   ld_q, ld_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              terr_q, terr_d;

   logic [1:0]        off_c;
   logic              mem_op_c;
   logic              is_half_c;
   logic              is_word_c;
   logic              mis_c;
   logic              access_c;
   logic [3:0]        mbe_c;
   logic [XLEN-1:0]   wdata_c;

   // Select the addressed byte/half and extend it according to the load width code.
   function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [31:0] sh;
      sh = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  extend_load = {{24{sh[7]}}, sh[7:0]};
         3'b001:  extend_load = {{16{sh[15]}}, sh[15:0]};
         3'b100:  extend_load = {24'b0, sh[7:0]};
         3'b101:  extend_load = {16'b0, sh[15:0]};
         default: extend_load = sh;
      endcase
   endfunction

   // Decode of the instruction currently sitting in the EX/MEM buffer.
   always_comb begin
      off_c     = ALU_out_MEM[1:0];
      mem_op_c  = valid_MEM & (mem_read_MEM | mem_write_MEM);
      is_half_c = (funct3_MEM[1:0] == 2'b01);
      is_word_c = funct3_MEM[1];
      mis_c     = mem_op_c & ((is_half_c & off_c[0]) | (is_word_c & (off_c != 2'b00)));
      access_c  = mem_op_c & ~mis_c;
      mbe_c     = 4'b0000;
      wdata_c   = '0;
      if (mem_write_MEM && !mem_read_MEM) begin
         case (funct3_MEM[1:0])
            2'b00:   mbe_c = 4'b0001 << off_c;
            2'b01:   mbe_c = 4'b0011 << off_c;
            default: mbe_c = 4'b1111;
         endcase
         wdata_c = rs2_MEM << {off_c, 3'b000};
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      mbe_d     = mbe_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      off_d     = off_q;
      f3_d      = f3_q;
      ld_d      = ld_q;
      cnt_d     = cnt_q;
      terr_d    = terr_q;
      stall_mem = 1'b0;

      case (state_q)
         S_IDLE: begin
            stall_mem = access_c;
            if (access_c) begin
               addr_d  = {ALU_out_MEM[31:2], 2'b00};
               mbe_d   = mbe_c;
               wdata_d = wdata_c;
               rd_d    = mem_read_MEM;
               wr_d    = mem_write_MEM;
               off_d   = off_c;
               f3_d    = funct3_MEM;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            stall_mem = 1'b1;
            if (dmem_resp) begin
               ld_d    = rd_q ? extend_load(dmem_rdata, off_q, f3_q) : '0;
               state_d = S_DONE;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
               terr_d  = 1'b1;
               ld_d    = '0;
               state_d = S_DONE;
            end else if (cnt_q < CNT_W'(TIMEOUT)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            // Result stays visible until MEM/WB accepts it.
            if (!hold_in) begin
               ld_d    = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         mbe_q   <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         off_q   <= '0;
         f3_q    <= '0;
         ld_q    <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         mbe_q   <= mbe_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         ld_q    <= ld_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

   assign dmem_address = addr_q;
   assign dmem_mbe     = mbe_q;
   assign dmem_wdata   = wdata_q;
   assign dmem_read    = (state_q == S_BUSY) & rd_q;
   assign dmem_write   = (state_q == S_BUSY) & wr_q;
   assign load_data    = ld_q;
   assign misaligned   = mis_c;
   assign timeout_err  = terr_q;

endmodule
